alu_seq: RTL and testbench
==========================

# alu_seq

Clocked, parametrised successor to the combinational/latched core ALU. Executes the 65C02 ALU operation set (logic, add/subtract, shifts and rotates, BIT, CMP, TSB/TRB) on WIDTH-bit operands, with a start/done handshake and registered results. Decimal-mode ADC/SBC is corrected one nibble per cycle. It sits between the instruction decoder and the accumulator/data-bus registers, and it reports flag updates with an explicit per-flag mask.

## Interface
Parameters:
- WIDTH, 8: operand and result width. Must be a multiple of 4 and at least 8.

Ports:
- fclk  in  1  system clock; all state updates on its rising edge.
- resb  in  1  reset; asynchronous, active-high.
- start  in  1  request an operation; accepted when busy=0.
- op  in  4  operation code (alu_pkg::alu_op_e).
- a_in  in  WIDTH  accumulator operand.
- b_in  in  WIDTH  memory/data-bus operand.
- c_in  in  1  carry flag in.
- d_in  in  1  decimal flag in.
- n_in, v_in  in  1 each  current N/V, used for pass-through.
- busy  out  1  high while a decimal sequence is in progress.
- done  out  1  one-cycle pulse; result and flags are valid.
- result  out  WIDTH  registered result.
- dest_mem  out  1  1 = result goes to memory (shift/rotate/TSB/TRB); 0 = accumulator or none.
- n_out, v_out, z_out, c_out  out  1 each  registered flags.
- flag_mask  out  4  {N,V,Z,C} flags to be written by the PSR.

## Operation
- Op codes: 0 AND, 1 ORA, 2 EOR, 3 ADC, 4 SBC, 5 ASL, 6 LSR, 7 ROL, 8 ROR, 9 BIT, A CMP, B TSB, C TRB. Codes D–F are illegal.
- Operands, c_in and d_in are captured on the accepting edge. Input changes after that edge have no effect on the operation.
- AND/ORA/EOR: result = a op b. Mask is NZ.
- ADC binary: {C,result} = a+b+c. V = signed overflow. Mask is NVZC.
- SBC binary: result = a+~b+c. C = no borrow. V = signed overflow. Mask is NVZC.
- ASL/LSR/ROL/ROR: operate on b_in, with dest_mem=1. C receives the bit shifted out. ROL and ROR take c_in as the shift-in bit. LSR forces N=0. Mask is NZC.
- BIT: N=b[W-1], V=b[W-2], Z=(a&b)==0. No result write; result=a. Mask is NVZ.
- CMP: diff = a−b. C = a≥b (unsigned). N = diff MSB. Z = diff==0. Mask is NZC. result=a.
- TSB: result = a|b. TRB: result = ~a&b. For both, Z=(a&b)==0, dest_mem=1, mask is Z.
- Illegal op: result=a, flags unchanged, mask=0. done still pulses.
- Decimal ADC/SBC (d_in=1): processed nibble-wise, least significant nibble first. The carry chains through the nibbles.
  - ADC: if nibble sum > 9, add 6 and set the nibble carry.
  - SBC: if the nibble borrows, subtract 6, modulo 16.
  - Non-BCD digits follow the same rule; no error is flagged.
  - N and Z come from the corrected result. V comes from the binary sum of the captured operands. C is the final decimal carry.
- State machine:
  - IDLE: on start, go to DEC if ADC/SBC with d_in=1, otherwise go to RES.
  - DEC: processes nibble k = 0..WIDTH/4−1, one per cycle. After the last nibble, go to RES.
  - RES: done=1. On start, re-enter DEC or RES directly (back-to-back). Otherwise go to IDLE.
- busy=1 only in DEC. start is ignored while busy=1.

## Timing
- Binary op: done in the cycle after the accepting edge (latency 1). Throughput is 1 op/cycle.
- Decimal op: done WIDTH/4+1 cycles after the accepting edge. For WIDTH=8 this is 3.
- result, flags, flag_mask and dest_mem update only at the edge entering RES. They are held until the next RES.
- Reset: state IDLE, all outputs 0, nibble counter 0.
- Reset asserted mid-DEC aborts the operation with no done. The first start after release is accepted normally.

## Configuration
- ALU_DECIMAL_EN defined: decimal path, DEC state and nibble counter are present.
- ALU_DECIMAL_EN undefined: d_in is ignored, ADC/SBC are always binary, busy is tied 0, and all ops complete with latency 1.

## Structure
- alu_pkg holds:
  - alu_op_e enum (4-bit, codes above).
  - alu_state_e (IDLE, DEC, RES).
  - Flag-mask bit position constants.
- Sub-module bcd_nibble_addsub: a 4-bit operand pair plus carry/borrow-in and a sub select, producing a corrected nibble and carry-out. Combinational. Instantiated once and time-multiplexed over the nibbles.

## Test plan
- WIDTH=8, ADC binary, a=7F, b=01, c=0 → result 80, N=1 V=1 Z=0 C=0, mask F, done 1 cycle after start.
- WIDTH=8, ADC decimal, a=58, b=46, c=1 → result 05, C=1, Z=0. busy high for 2 cycles, done 3 cycles after start.
- WIDTH=8, SBC decimal, a=12, b=21, c=1 → result 91, C=0, N=1.
- WIDTH=8, back-to-back binary ops:
  - ROR b=01, c=1 → result 80, C=1, N=1, dest_mem=1.
  - Next cycle, CMP a=b=40 → C=1, Z=1, N=0, mask NZC.
- WIDTH=16, ADC decimal, a=9999, b=0001, c=0 → result 0000, C=1, Z=1, done 5 cycles after start.
- Reset mid-operation: assert resb during DEC cycle 1 → no done, all outputs 0. Then TSB a=0F, b=30 → result 3F, Z=1, mask Z.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the clocked 65C02-style ALU (alu_seq).
//
// Contents:
//   alu_op_e     - 4-bit operation codes (0x0..0xC legal, 0xD..0xF illegal)
//   ST_*         - FSM state encodings, also wrapped in alu_state_e
//   FLAG_*       - bit positions of {N,V,Z,C} inside flag_mask
//   MASK_*       - the flag-mask values used by the operation groups
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'h0,
        OP_ORA = 4'h1,
        OP_EOR = 4'h2,
        OP_ADC = 4'h3,
        OP_SBC = 4'h4,
        OP_ASL = 4'h5,
        OP_LSR = 4'h6,
        OP_ROL = 4'h7,
        OP_ROR = 4'h8,
        OP_BIT = 4'h9,
        OP_CMP = 4'hA,
        OP_TSB = 4'hB,
        OP_TRB = 4'hC
    } alu_op_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DEC  = 2'd1;
    localparam logic [1:0] ST_RES  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        DEC  = ST_DEC,
        RES  = ST_RES
    } alu_state_e;

    // Bit positions inside flag_mask = {N,V,Z,C}.
    localparam int FLAG_N = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    localparam logic [3:0] MASK_NONE = 4'b0000;
    localparam logic [3:0] MASK_NZ   = 4'b1010;
    localparam logic [3:0] MASK_NZC  = 4'b1011;
    localparam logic [3:0] MASK_NVZ  = 4'b1110;
    localparam logic [3:0] MASK_NVZC = 4'b1111;
    localparam logic [3:0] MASK_Z    = 4'b0010;

endpackage

// File: rtl/bcd_nibble_addsub.sv
// bcd_nibble_addsub: one decimal digit of a BCD add or subtract.
//
// Ports:
//   a, b  in  4  operand digits
//   cin   in  1  carry in (add) / not-borrow in (subtract)
//   sub   in  1  1 = a - b, 0 = a + b
//   sum   out 4  corrected digit
//   cout  out 1  decimal carry out (add) / not-borrow out (subtract)
//
// Purely combinational. Subtraction uses the 6502 convention: a + ~b + cin,
// where a carry out of the nibble means "no borrow". Non-BCD digits are
// corrected by the same rule without any error indication.
module bcd_nibble_addsub (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       sub,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] b_eff;
    logic [4:0] raw;

    always_comb begin
        b_eff = sub ? ~b : b;
        raw   = {1'b0, a} + {1'b0, b_eff} + {4'b0000, cin};
        if (sub) begin
            // A borrowed digit wrapped through 16; pull it back into 0..9.
            cout = raw[4];
            sum  = raw[4] ? raw[3:0] : (raw[3:0] - 4'd6);
        end else if (raw > 5'd9) begin
            // Skip the six unused codes A..F and ripple a decimal carry.
            cout = 1'b1;
            sum  = raw[3:0] + 4'd6;
        end else begin
            cout = 1'b0;
            sum  = raw[3:0];
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: clocked 65C02 ALU with start/done handshake and registered outputs.
//
// Optional feature macro: ALU_DECIMAL_EN
//   defined   - decimal ADC/SBC is corrected one nibble per cycle in DEC
//   undefined - d_in is ignored, ADC/SBC are binary, busy is tied low
//
// Ports:
//   fclk, resb           clock, asynchronous active-high reset
//   start, op            request and 4-bit op code (alu_pkg::alu_op_e)
//   a_in, b_in           accumulator / data-bus operands (WIDTH bits)
//   c_in, d_in           carry and decimal flags
//   n_in, v_in           current N/V, passed through for flags not written
//   busy                 high while a decimal sequence runs (start ignored)
//   done                 one-cycle pulse; result/flags valid
//   result, dest_mem     registered result; 1 = write back to memory
//   n_out..c_out         registered flags
//   flag_mask            {N,V,Z,C} flags the PSR must update
//
// Handshake: start is accepted on a rising edge of fclk whenever busy=0
// (IDLE or RES). Operands, c_in and d_in are sampled on that edge only.
// done is high for exactly the one cycle spent in RES; a start seen in RES
// chains the next operation with no idle gap.
//
// WIDTH must be a multiple of 4 and at least 8.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             fclk,
    input  logic             resb,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    input  logic             d_in,
    input  logic             n_in,
    input  logic             v_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             dest_mem,
    output logic             n_out,
    output logic             v_out,
    output logic             z_out,
    output logic             c_out,
    output logic [3:0]       flag_mask
);

    alu_state_e state;
    alu_op_e    op_e;

    assign op_e = alu_op_e'(op);

    // ------------------------------------------------------------------
    // Single-cycle result, computed straight from the live inputs so that
    // the accepting edge can load it directly into the output registers.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   cmp_ext;
    logic             add_v;
    logic [WIDTH-1:0] bin_res;
    logic             bin_n;
    logic             bin_v;
    logic             bin_z;
    logic             bin_c;
    logic             bin_dest;
    logic [3:0]       bin_mask;

    always_comb begin
        addend  = (op_e == OP_SBC) ? ~b_in : b_in;
        sum_ext = {1'b0, a_in} + {1'b0, addend} + {{WIDTH{1'b0}}, c_in};
        cmp_ext = {1'b0, a_in} + {1'b0, ~b_in} + {{WIDTH{1'b0}}, 1'b1};
        // Overflow: both addends share a sign that the sum does not.
        add_v   = (a_in[WIDTH-1] == addend[WIDTH-1]) &&
                  (sum_ext[WIDTH-1] != a_in[WIDTH-1]);

        bin_res  = a_in;
        bin_n    = n_in;
        bin_v    = v_in;
        bin_z    = ~|a_in;
        bin_c    = c_in;
        bin_dest = 1'b0;
        bin_mask = MASK_NONE;

        case (op_e)
            OP_AND, OP_ORA, OP_EOR: begin
                if (op_e == OP_AND)      bin_res = a_in & b_in;
                else if (op_e == OP_ORA) bin_res = a_in | b_in;
                else                     bin_res = a_in ^ b_in;
                bin_n    = bin_res[WIDTH-1];
                bin_z    = ~|bin_res;
                bin_mask = MASK_NZ;
            end
            OP_ADC, OP_SBC: begin
                bin_res  = sum_ext[WIDTH-1:0];
                bin_c    = sum_ext[WIDTH];
                bin_v    = add_v;
                bin_n    = bin_res[WIDTH-1];
                bin_z    = ~|bin_res;
                bin_mask = MASK_NVZC;
            end
            OP_ASL, OP_LSR, OP_ROL, OP_ROR: begin
                case (op_e)
                    OP_ASL:  {bin_c, bin_res} = {b_in, 1'b0};
                    OP_LSR:  {bin_res, bin_c} = {1'b0, b_in};
                    OP_ROL:  {bin_c, bin_res} = {b_in, c_in};
                    default: {bin_res, bin_c} = {c_in, b_in};
                endcase
                bin_n    = bin_res[WIDTH-1];
                bin_z    = ~|bin_res;
                bin_dest = 1'b1;
                bin_mask = MASK_NZC;
            end
            OP_BIT: begin
                bin_n    = b_in[WIDTH-1];
                bin_v    = b_in[WIDTH-2];
                bin_z    = ~|(a_in & b_in);
                bin_mask = MASK_NVZ;
            end
            OP_CMP: begin
                bin_c    = cmp_ext[WIDTH];
                bin_n    = cmp_ext[WIDTH-1];
                bin_z    = ~|cmp_ext[WIDTH-1:0];
                bin_mask = MASK_NZC;
            end
            OP_TSB, OP_TRB: begin
                bin_res  = (op_e == OP_TSB) ? (a_in | b_in) : (~a_in & b_in);
                bin_z    = ~|(a_in & b_in);
                bin_dest = 1'b1;
                bin_mask = MASK_Z;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Decimal datapath: one shared nibble corrector stepped over the digits.
    // ------------------------------------------------------------------
    logic start_dec;

`ifdef ALU_DECIMAL_EN
    localparam int NIBBLES = WIDTH / 4;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    logic [CNT_W-1:0] nib_cnt;
    logic [WIDTH-1:0] dec_a;
    logic [WIDTH-1:0] dec_b;
    logic [WIDTH-1:0] dec_acc;
    logic [WIDTH-1:0] dec_full;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             dec_sub;
    logic             dec_carry;
    logic             dec_v;
    logic [3:0]       nib_sum;
    logic             nib_cout;

    assign start_dec = d_in && ((op_e == OP_ADC) || (op_e == OP_SBC));

    always_comb begin
        a_sh     = dec_a >> {nib_cnt, 2'b00};
        b_sh     = dec_b >> {nib_cnt, 2'b00};
        // dec_acc is cleared at capture and each digit is written once,
        // so OR-ing the new digit into place is enough.
        dec_full = dec_acc | ({{(WIDTH-4){1'b0}}, nib_sum} << {nib_cnt, 2'b00});
    end

    bcd_nibble_addsub u_nibble (
        .a    (a_sh[3:0]),
        .b    (b_sh[3:0]),
        .cin  (dec_carry),
        .sub  (dec_sub),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    always_ff @(posedge fclk or posedge resb) begin
        if (resb) begin
            nib_cnt   <= '0;
            dec_a     <= '0;
            dec_b     <= '0;
            dec_acc   <= '0;
            dec_sub   <= 1'b0;
            dec_carry <= 1'b0;
            dec_v     <= 1'b0;
        end else if (state != DEC) begin
            if (start && start_dec) begin
                nib_cnt   <= '0;
                dec_a     <= a_in;
                dec_b     <= b_in;
                dec_acc   <= '0;
                dec_sub   <= (op_e == OP_SBC);
                dec_carry <= c_in;
                // V is defined on the binary sum of the original operands.
                dec_v     <= add_v;
            end
        end else begin
            dec_acc   <= dec_full;
            dec_carry <= nib_cout;
            nib_cnt   <= (nib_cnt == LAST_NIB) ? '0 : nib_cnt + 1'b1;
        end
    end

    assign busy = (state == DEC);
`else
    logic unused_d;

    assign start_dec = 1'b0;
    assign unused_d  = d_in;
    assign busy      = 1'b0;
`endif

    assign done = (state == RES);

    // ------------------------------------------------------------------
    // Control FSM and output registers. Outputs only change on the edge
    // that enters RES and are held until the next one.
    // ------------------------------------------------------------------
    always_ff @(posedge fclk or posedge resb) begin
        if (resb) begin
            state     <= IDLE;
            result    <= '0;
            dest_mem  <= 1'b0;
            n_out     <= 1'b0;
            v_out     <= 1'b0;
            z_out     <= 1'b0;
            c_out     <= 1'b0;
            flag_mask <= '0;
        end else begin
            case (state)
                IDLE, RES: begin
                    if (!start) begin
                        state <= IDLE;
                    end else if (start_dec) begin
                        state <= DEC;
                    end else begin
                        state     <= RES;
                        result    <= bin_res;
                        dest_mem  <= bin_dest;
                        n_out     <= bin_n;
                        v_out     <= bin_v;
                        z_out     <= bin_z;
                        c_out     <= bin_c;
                        flag_mask <= bin_mask;
                    end
                end
`ifdef ALU_DECIMAL_EN
                DEC: begin
                    if (nib_cnt == LAST_NIB) begin
                        state     <= RES;
                        result    <= dec_full;
                        dest_mem  <= 1'b0;
                        n_out     <= dec_full[WIDTH-1];
                        v_out     <= dec_v;
                        z_out     <= ~|dec_full;
                        c_out     <= nib_cout;
                        flag_mask <= MASK_NVZC;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH=8 and WIDTH=16 copies).
// Honours ALU_DECIMAL_EN the same way as the design.
`timescale 1ns/1ps
module tb_alu_seq;

`ifdef ALU_DECIMAL_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] res;
        logic [3:0]  flags;   // {N,V,Z,C}
        logic [3:0]  mask;
        logic        dest;
    } obs_t;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- clock / reset ----------------
    logic fclk = 1'b0;
    logic resb;
    always #5 fclk = ~fclk;

    // ---------------- DUT signals ----------------
    logic        start8, c8, d8, ni8, vi8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, dest8, n8, v8, z8, cc8;
    logic [7:0]  res8;
    logic [3:0]  mask8;

    logic        start16, c16, d16, ni16, vi16;
    logic [3:0]  op16;
    logic [15:0] a16, b16;
    logic        busy16, done16, dest16, n16, v16, z16, cc16;
    logic [15:0] res16;
    logic [3:0]  mask16;

    alu_seq #(.WIDTH(8)) dut8 (
        .fclk(fclk), .resb(resb), .start(start8), .op(op8), .a_in(a8), .b_in(b8),
        .c_in(c8), .d_in(d8), .n_in(ni8), .v_in(vi8), .busy(busy8), .done(done8),
        .result(res8), .dest_mem(dest8), .n_out(n8), .v_out(v8), .z_out(z8),
        .c_out(cc8), .flag_mask(mask8)
    );

    alu_seq #(.WIDTH(16)) dut16 (
        .fclk(fclk), .resb(resb), .start(start16), .op(op16), .a_in(a16), .b_in(b16),
        .c_in(c16), .d_in(d16), .n_in(ni16), .v_in(vi16), .busy(busy16), .done(done16),
        .result(res16), .dest_mem(dest16), .n_out(n16), .v_out(v16), .z_out(z16),
        .c_out(cc16), .flag_mask(mask16)
    );

    // ---------------- reference model ----------------
    function automatic int bcd2int(int v, int nd);
        int r = 0;
        for (int i = nd - 1; i >= 0; i--) r = r * 10 + ((v >> (4 * i)) & 15);
        return r;
    endfunction

    function automatic int int2bcd(int v, int nd);
        int r = 0;
        for (int i = 0; i < nd; i++) begin
            r = r | ((v % 10) << (4 * i));
            v = v / 10;
        end
        return r;
    endfunction

    function automatic obs_t ref_model(int w, int op, int a, int b, int c, int d);
        obs_t e;
        int m, msb, bb, t, nd, lim, val, r, diff;
        logic fn, fv, fz, fc;
        m = (1 << w) - 1; msb = 1 << (w - 1); nd = w / 4;
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        e = '0; r = a; fn = 0; fv = 0; fz = 0; fc = 0;
        case (op)
            0, 1, 2: begin
                r = (op == 0) ? (a & b) : (op == 1) ? (a | b) : (a ^ b);
                fn = (r & msb) != 0; fz = (r == 0); e.mask = 4'b1010;
            end
            3, 4: begin
                bb = (op == 4) ? (~b & m) : b;
                t = a + bb + c;
                r = t & m; fc = (t > m);
                fv = ((a ^ t) & (bb ^ t) & msb) != 0;
                if (DEC_EN && d != 0) begin
                    if (op == 3) begin
                        val = bcd2int(a, nd) + bcd2int(b, nd) + c;
                        fc = (val >= lim);
                        r = int2bcd(val % lim, nd);
                    end else begin
                        val = bcd2int(a, nd) - bcd2int(b, nd) - (1 - c);
                        fc = (val >= 0);
                        r = int2bcd((val + lim) % lim, nd);
                    end
                end
                fn = (r & msb) != 0; fz = (r == 0); e.mask = 4'b1111;
            end
            5, 6, 7, 8: begin
                case (op)
                    5: begin r = (b << 1) & m; fc = (b & msb) != 0; end
                    6: begin r = b >> 1; fc = b & 1; end
                    7: begin r = ((b << 1) | c) & m; fc = (b & msb) != 0; end
                    default: begin r = (b >> 1) | (c != 0 ? msb : 0); fc = b & 1; end
                endcase
                fn = (r & msb) != 0; fz = (r == 0); e.mask = 4'b1011; e.dest = 1;
            end
            9: begin
                fn = (b & msb) != 0; fv = (b & (msb >> 1)) != 0; fz = ((a & b) == 0);
                e.mask = 4'b1110;
            end
            10: begin
                diff = (a - b) & m;
                fc = (a >= b); fn = (diff & msb) != 0; fz = (diff == 0); e.mask = 4'b1011;
            end
            11, 12: begin
                r = (op == 11) ? (a | b) : ((~a) & b & m);
                fz = ((a & b) == 0); e.mask = 4'b0010; e.dest = 1;
            end
            default: ;
        endcase
        e.res = 16'(r);
        e.flags = {fn, fv, fz, fc};
        return e;
    endfunction

    function automatic int exp_lat(int w, int op, int d);
        return (DEC_EN && d != 0 && (op == 3 || op == 4)) ? (w / 4 + 1) : 1;
    endfunction

    function automatic int rand_bcd(int nd);
        int r = 0;
        for (int i = 0; i < nd; i++) r = r | ($urandom_range(0, 9) << (4 * i));
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    // Issue one op and wait (bounded) for done; inputs are scrambled right
    // after the accepting edge. lat = negedges until done (20 = timeout).
    task automatic drive8(input int o, input int a, input int b, input int c, input int d,
                          output obs_t got, output int lat, output int bcnt);
        bit seen = 0;
        @(negedge fclk);
        op8 = 4'(o); a8 = 8'(a); b8 = 8'(b); c8 = c[0]; d8 = d[0];
        ni8 = $urandom; vi8 = $urandom; start8 = 1'b1;
        lat = 0; bcnt = 0; got = '0;
        while (!seen && lat < 20) begin
            @(negedge fclk);
            lat++;
            if (lat == 1) begin
                start8 = 1'b0; op8 = 4'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
                c8 = $urandom; d8 = $urandom;
            end
            if (busy8) bcnt++;
            if (done8) begin
                seen = 1;
                got.res = {8'h00, res8}; got.flags = {n8, v8, z8, cc8};
                got.mask = mask8; got.dest = dest8;
            end
        end
    endtask

    task automatic drive16(input int o, input int a, input int b, input int c, input int d,
                           output obs_t got, output int lat, output int bcnt);
        bit seen = 0;
        @(negedge fclk);
        op16 = 4'(o); a16 = 16'(a); b16 = 16'(b); c16 = c[0]; d16 = d[0];
        ni16 = $urandom; vi16 = $urandom; start16 = 1'b1;
        lat = 0; bcnt = 0; got = '0;
        while (!seen && lat < 20) begin
            @(negedge fclk);
            lat++;
            if (lat == 1) begin
                start16 = 1'b0; op16 = 4'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
                c16 = $urandom; d16 = $urandom;
            end
            if (busy16) bcnt++;
            if (done16) begin
                seen = 1;
                got.res = res16; got.flags = {n16, v16, z16, cc16};
                got.mask = mask16; got.dest = dest16;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        start8 = 0; op8 = 0; a8 = 0; b8 = 0; c8 = 0; d8 = 0; ni8 = 0; vi8 = 0;
        start16 = 0; op16 = 0; a16 = 0; b16 = 0; c16 = 0; d16 = 0; ni16 = 0; vi16 = 0;
        resb = 1'b1;
        repeat (3) @(negedge fclk);
        n_checks++;
        if ({busy8, done8, res8, dest8, n8, v8, z8, cc8, mask8} !== '0) begin
            n_fail++;
            $display("FAIL reset8: got %h required 0", {busy8, done8, res8, dest8, n8, v8, z8, cc8, mask8});
        end
        n_checks++;
        if ({busy16, done16, res16, dest16, n16, v16, z16, cc16, mask16} !== '0) begin
            n_fail++;
            $display("FAIL reset16: got %h required 0", {busy16, done16, res16, dest16, n16, v16, z16, cc16, mask16});
        end
        resb = 1'b0;
    endtask

    task automatic test_adc_binary();
        obs_t got; int lat, bc;
        drive8(3, 'h7F, 'h01, 0, 0, got, lat, bc);
        n_checks++;
        if (got.res[7:0] !== 8'h80 || got.flags !== 4'b1100 || got.mask !== 4'hF || got.dest !== 1'b0) begin
            n_fail++;
            $display("FAIL adc_bin_value: got res=%h flags=%b mask=%b dest=%b required res=80 flags=1100 mask=1111 dest=0",
                     got.res[7:0], got.flags, got.mask, got.dest);
        end
        n_checks++;
        if (lat !== 1) begin
            n_fail++; $display("FAIL adc_bin_latency: got %0d required 1", lat);
        end
        @(negedge fclk);
        n_checks++;
        if (done8 !== 1'b0) begin
            n_fail++; $display("FAIL done_pulse: done still %b one cycle later, required 0", done8);
        end
    endtask

    task automatic test_decimal();
        obs_t got, e; int lat, bc;
        drive8(3, 'h58, 'h46, 1, 1, got, lat, bc);
        e = ref_model(8, 3, 'h58, 'h46, 1, 1);
        n_checks++;
        if (got.res !== e.res || got.mask !== e.mask || (got.flags & e.mask) !== (e.flags & e.mask)) begin
            n_fail++; $display("FAIL adc_dec8: got %h required %h", got, e);
        end
        n_checks++;
        if (lat !== exp_lat(8, 3, 1) || bc !== (DEC_EN ? 2 : 0)) begin
            n_fail++; $display("FAIL adc_dec8_timing: got lat=%0d busy=%0d required lat=%0d busy=%0d",
                               lat, bc, exp_lat(8, 3, 1), DEC_EN ? 2 : 0);
        end
        drive8(4, 'h12, 'h21, 1, 1, got, lat, bc);
        e = ref_model(8, 4, 'h12, 'h21, 1, 1);
        n_checks++;
        if (got.res !== e.res || got.mask !== e.mask || (got.flags & e.mask) !== (e.flags & e.mask)) begin
            n_fail++; $display("FAIL sbc_dec8: got %h required %h", got, e);
        end
        drive16(3, 'h9999, 'h0001, 0, 1, got, lat, bc);
        e = ref_model(16, 3, 'h9999, 'h0001, 0, 1);
        n_checks++;
        if (got.res !== e.res || got.mask !== e.mask || (got.flags & e.mask) !== (e.flags & e.mask)) begin
            n_fail++; $display("FAIL adc_dec16: got %h required %h", got, e);
        end
        n_checks++;
        if (lat !== exp_lat(16, 3, 1) || bc !== (DEC_EN ? 4 : 0)) begin
            n_fail++; $display("FAIL adc_dec16_timing: got lat=%0d busy=%0d required lat=%0d", lat, bc, exp_lat(16, 3, 1));
        end
    endtask

    task automatic test_back_to_back();
        obs_t got, e1, e2;
        e1 = ref_model(8, 8, 'h00, 'h01, 1, 0);
        e2 = ref_model(8, 10, 'h40, 'h40, 0, 0);
        @(negedge fclk);
        op8 = 4'h8; a8 = 8'h00; b8 = 8'h01; c8 = 1; d8 = 0; start8 = 1;
        @(negedge fclk);
        got = '0; got.res = {8'h00, res8}; got.flags = {n8, v8, z8, cc8}; got.mask = mask8; got.dest = dest8;
        n_checks++;
        if (done8 !== 1'b1 || got.res !== e1.res || got.mask !== e1.mask || got.dest !== e1.dest ||
            (got.flags & e1.mask) !== (e1.flags & e1.mask)) begin
            n_fail++; $display("FAIL b2b_ror: got done=%b %h required done=1 %h", done8, got, e1);
        end
        op8 = 4'hA; a8 = 8'h40; b8 = 8'h40; c8 = 0;
        @(negedge fclk);
        got = '0; got.res = {8'h00, res8}; got.flags = {n8, v8, z8, cc8}; got.mask = mask8; got.dest = dest8;
        start8 = 0;
        n_checks++;
        if (done8 !== 1'b1 || got.res !== e2.res || got.mask !== e2.mask || got.dest !== e2.dest ||
            (got.flags & e2.mask) !== (e2.flags & e2.mask)) begin
            n_fail++; $display("FAIL b2b_cmp: got done=%b %h required done=1 %h", done8, got, e2);
        end
        @(negedge fclk);
        n_checks++;
        if (done8 !== 1'b0) begin
            n_fail++; $display("FAIL b2b_idle: done=%b required 0", done8);
        end
    endtask

    task automatic test_reset_mid_op();
        obs_t got; int lat, bc, stray;
        @(negedge fclk);
        op8 = 4'h3; a8 = 8'h58; b8 = 8'h46; c8 = 1; d8 = 1; start8 = 1;
        @(negedge fclk);
        start8 = 0;
        resb = 1'b1;
        #1;
        n_checks++;
        if ({busy8, done8, res8, dest8, n8, v8, z8, cc8, mask8} !== '0) begin
            n_fail++; $display("FAIL reset_mid: got %h required 0", {busy8, done8, res8, dest8, n8, v8, z8, cc8, mask8});
        end
        @(negedge fclk);
        resb = 1'b0;
        stray = 0;
        repeat (4) begin
            @(negedge fclk);
            if (done8) stray++;
        end
        n_checks++;
        if (stray !== 0) begin
            n_fail++; $display("FAIL reset_no_done: got %0d done cycles required 0", stray);
        end
        drive8(11, 'h0F, 'h30, 0, 0, got, lat, bc);
        n_checks++;
        if (got.res[7:0] !== 8'h3F || got.flags[1] !== 1'b1 || got.mask !== 4'b0010 || got.dest !== 1'b1 || lat !== 1) begin
            n_fail++; $display("FAIL tsb_after_reset: got res=%h z=%b mask=%b dest=%b lat=%0d required 3F 1 0010 1 1",
                               got.res[7:0], got.flags[1], got.mask, got.dest, lat);
        end
    endtask

    task automatic test_random();
        obs_t got, e; int o, a, b, c, d, lat, bc, w;
        for (int i = 0; i < 360; i++) begin
            w = (i < 300) ? 8 : 16;
            o = $urandom_range(0, 15);
            c = $urandom_range(0, 1); d = $urandom_range(0, 1);
            if ((o == 3 || o == 4) && d == 1) begin
                a = rand_bcd(w / 4); b = rand_bcd(w / 4);
            end else begin
                a = $urandom_range(0, (1 << w) - 1); b = $urandom_range(0, (1 << w) - 1);
            end
            if (w == 8) drive8(o, a, b, c, d, got, lat, bc);
            else        drive16(o, a, b, c, d, got, lat, bc);
            e = ref_model(w, o, a, b, c, d);
            n_checks++;
            if (got.res !== e.res || got.mask !== e.mask || got.dest !== e.dest ||
                (got.flags & e.mask) !== (e.flags & e.mask) || lat !== exp_lat(w, o, d)) begin
                n_fail++;
                $display("FAIL random w=%0d op=%0h a=%h b=%h c=%0d d=%0d: got %h lat=%0d required %h lat=%0d",
                         w, o, a, b, c, d, got, lat, e, exp_lat(w, o, d));
            end
        end
    endtask

    initial begin
        test_reset();
        test_adc_binary();
        test_decimal();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
